// File: rtl/add16.sv
// 16-bit ripple-carry adder with a registered sum, built from gate-level cells.
// Everything below the register is NAND-derived; the carry out of bit 15 is dropped.

module add16_nand2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

module add16_not1 (
  input  logic a_i,
  output logic y_o
);
  add16_nand2 u_nand (.a_i(a_i), .b_i(a_i), .y_o(y_o));
endmodule

module add16_and2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic n_ab;

  add16_nand2 u_nand (.a_i(a_i),  .b_i(b_i), .y_o(n_ab));
  add16_not1  u_inv  (.a_i(n_ab), .y_o(y_o));
endmodule

module add16_or2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic n_a;
  logic n_b;

  // De Morgan: a | b = ~(~a & ~b)
  add16_not1  u_inv_a (.a_i(a_i), .y_o(n_a));
  add16_not1  u_inv_b (.a_i(b_i), .y_o(n_b));
  add16_nand2 u_nand  (.a_i(n_a), .b_i(n_b), .y_o(y_o));
endmodule

module add16_xor2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic n_ab;
  logic n_a_nab;
  logic n_b_nab;

  // Classic four-NAND exclusive-or.
  add16_nand2 u_nand0 (.a_i(a_i),     .b_i(b_i),     .y_o(n_ab));
  add16_nand2 u_nand1 (.a_i(a_i),     .b_i(n_ab),    .y_o(n_a_nab));
  add16_nand2 u_nand2 (.a_i(b_i),     .b_i(n_ab),    .y_o(n_b_nab));
  add16_nand2 u_nand3 (.a_i(n_a_nab), .b_i(n_b_nab), .y_o(y_o));
endmodule

module add16_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  add16_xor2 u_sum   (.a_i(a_i), .b_i(b_i), .y_o(s_o));
  add16_and2 u_carry (.a_i(a_i), .b_i(b_i), .y_o(c_o));
endmodule

module add16_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;
  logic g;
  logic pc;

  // Propagate p = a ^ b, generate g = a & b; carry = g | (c & p).
  add16_xor2 u_prop  (.a_i(a_i), .b_i(b_i), .y_o(p));
  add16_and2 u_gen   (.a_i(a_i), .b_i(b_i), .y_o(g));
  add16_xor2 u_sum   (.a_i(p),   .b_i(c_i), .y_o(s_o));
  add16_and2 u_pc    (.a_i(c_i), .b_i(p),   .y_o(pc));
  add16_or2  u_carry (.a_i(g),   .b_i(pc),  .y_o(c_o));
endmodule

module add16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  logic [15:0] out_d;
  logic [15:0] out_q;
  logic        carry_out_unused;

  // Each stage owns its carry net so the chain is a set of distinct wires.
  for (genvar i = 0; i < 15; i++) begin : g_bit
    logic co;
    if (i == 0) begin : g_half
      add16_half_adder u_ha (
        .a_i (a[i]),
        .b_i (b[i]),
        .s_o (out_d[i]),
        .c_o (co)
      );
    end else begin : g_full
      add16_full_adder u_fa (
        .a_i (a[i]),
        .b_i (b[i]),
        .c_i (g_bit[i-1].co),
        .s_o (out_d[i]),
        .c_o (co)
      );
    end
  end

  // Top bit: its carry is the modulo-2^16 wrap and goes nowhere.
  add16_full_adder u_fa_msb (
    .a_i (a[15]),
    .b_i (b[15]),
    .c_i (g_bit[14].co),
    .s_o (out_d[15]),
    .c_o (carry_out_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_add16.sv
// Directed and randomized checks of add16 against an arithmetic model of (a + b) mod 2^16.

module tb_add16;
  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  add16 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .out (out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition reduced modulo 2^16.
  function automatic logic [15:0] ref_add(input int unsigned x, input int unsigned y);
    int unsigned s;
    s = (x + y) % 65536;
    return s[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    total++;
    assert (out === exp) else begin
      bad++;
      $error("FAIL %s: out=%h expected=%h", tag, out, exp);
    end
  endtask

  // Drive operands away from the edge, clock once, compare just after the edge.
  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check(tag, ref_add(x, y));
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] ra;
    logic [15:0] rb;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    a     = 16'h1234;
    b     = 16'h1111;

    // Reset: asynchronous clear, held while clocking, then release.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_no_edge", 16'h0000);
    @(posedge clk);
    #1;
    check("rst_first_edge", 16'h2345);

    // Basic sums
    step("basic0", 16'h0001, 16'h1080);
    check("basic0_const", 16'h1081);
    step("basic1", 16'h0001, 16'h0001);
    check("basic1_const", 16'h0002);
    step("basic2", 16'hA211, 16'h0730);
    check("basic2_const", 16'hA941);

    // Wrap and signed cases
    step("signed_ovf", 16'h8001, 16'h8003);
    check("signed_ovf_const", 16'h0004);
    step("one_plus_m5", 16'h0001, 16'hFFFB);
    check("one_plus_m5_const", 16'hFFFC);

    // Full carry ripple
    step("ripple_ffff", 16'hFFFF, 16'h0001);
    check("ripple_ffff_const", 16'h0000);
    step("ripple_7fff", 16'h7FFF, 16'h0001);
    check("ripple_7fff_const", 16'h8000);
    step("alt_bits", 16'hAAAA, 16'h5555);
    check("alt_bits_const", 16'hFFFF);

    // Back-to-back random stream through the expected queue
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      exp_q.push_back(ref_add(a, b));
      @(posedge clk);
      #1;
      check("stream", exp_q.pop_front());
    end

    // Mid-cycle operand changes must not reach out before the edge
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      prev = out;
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      a = ra;
      b = rb;
      #2;
      a = ra ^ 16'h00FF;
      #1;
      a = ra;
      #1;
      check("midcycle_hold", prev);
      @(posedge clk);
      #1;
      check("midcycle_edge", ref_add(ra, rb));
    end

    // Reset pulsed between edges while streaming
    for (int i = 0; i < 4; i++) begin
      step("pre_rst_stream", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_clear", 16'h0000);
      #1;
      rst = 1'b0;
      ra = 16'($urandom);
      rb = 16'($urandom);
      a = ra;
      b = rb;
      #1;
      check("mid_rst_no_stale", 16'h0000);
      @(posedge clk);
      #1;
      check("post_rst_live", ref_add(ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
